// File: rtl/pipe_stall_ctrl.sv
// Pipeline hold/bubble control for the ID/EX register: load-use hazard bubbling,
// branch flush squashing and a data-cache access FSM with timeout and stall counting.
module pipe_stall_ctrl #(
  parameter int unsigned MAX_WAIT = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       IFID_read1RegSel,
  input  logic [2:0]       IFID_read2RegSel,
  input  logic             IFID_read1Used,
  input  logic             IFID_read2Used,
  input  logic             IDEX_MemRead,
  input  logic [2:0]       IDEX_Write_register,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic             mem_done,
  input  logic             flush,
  output logic             mem_req,
  output logic             DC_Stall,
  output logic             stall,
  output logic             nop,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_access;
  logic       timeout;
  logic       hz;

  assign mem_access = EXMEM_MemRead | EXMEM_MemWrite;
  assign timeout    = (state == BUSY) && (wait_cnt == WAIT_LIMIT);

  assign hz = IDEX_MemRead &
              ((IFID_read1Used & (IDEX_Write_register == IFID_read1RegSel)) |
               (IFID_read2Used & (IDEX_Write_register == IFID_read2RegSel)));

  // A cache freeze outranks everything: ID/EX holds, so a flush is dropped and
  // must be re-presented by its source once the freeze lifts.
  always_comb begin
    mem_req  = (state == IDLE) & mem_access;
    DC_Stall = ((state == IDLE) & mem_access & ~mem_done) |
               ((state == BUSY) & ~mem_done & ~timeout);
    stall    = 1'b0;
    nop      = 1'b0;
    if (!DC_Stall) begin
      if (flush) begin
        nop = 1'b1;
      end else if (hz) begin
        stall = 1'b1;
        nop   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_access && !mem_done) begin
            state    <= BUSY;
            wait_cnt <= 8'd1;
          end
        end
        BUSY: begin
          if (mem_done) begin
            state <= IDLE;
          end else if (timeout) begin
            state   <= IDLE;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if ((DC_Stall || stall) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table plus multi-cycle miss, priority,
// reset-abort, timeout and counter saturation sequences.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  r1sel, r2sel, wreg;
  logic        r1used, r2used, idex_mr;
  logic        ex_rd, ex_wr, done, flush;
  logic        mem_req, dc_stall, stall, nop, mem_err;
  logic [15:0] stall_cycles;

  logic        ex_rd2, ex_wr2, done2;
  logic        mem_req2, dc_stall2, stall2, nop2, mem_err2;
  logic [2:0]  stall_cycles2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [2:0] r1, r2;
    logic       u1, u2, mr;
    logic [2:0] wr;
    logic       er, ew, dn, fl;
    logic       q, d, s, n;
  } vec_t;

  typedef struct packed {
    logic q, d, s, n;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[15];

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_read1RegSel(r1sel), .IFID_read2RegSel(r2sel),
    .IFID_read1Used(r1used), .IFID_read2Used(r2used),
    .IDEX_MemRead(idex_mr), .IDEX_Write_register(wreg),
    .EXMEM_MemRead(ex_rd), .EXMEM_MemWrite(ex_wr),
    .mem_done(done), .flush(flush),
    .mem_req(mem_req), .DC_Stall(dc_stall), .stall(stall), .nop(nop),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  pipe_stall_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .IFID_read1RegSel(r1sel), .IFID_read2RegSel(r2sel),
    .IFID_read1Used(r1used), .IFID_read2Used(r2used),
    .IDEX_MemRead(idex_mr), .IDEX_Write_register(wreg),
    .EXMEM_MemRead(ex_rd2), .EXMEM_MemWrite(ex_wr2),
    .mem_done(done2), .flush(flush),
    .mem_req(mem_req2), .DC_Stall(dc_stall2), .stall(stall2), .nop(nop2),
    .mem_err(mem_err2), .stall_cycles(stall_cycles2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(int r1, int r2, int u1, int u2, int mr, int wr,
                              int er, int ew, int dn, int fl,
                              int q, int d, int s, int n);
    vec_t v;
    v.r1 = 3'(r1); v.r2 = 3'(r2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.mr = 1'(mr); v.wr = 3'(wr); v.er = 1'(er); v.ew = 1'(ew);
    v.dn = 1'(dn); v.fl = 1'(fl);
    v.q = 1'(q); v.d = 1'(d); v.s = 1'(s); v.n = 1'(n);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    r1sel = v.r1; r2sel = v.r2; r1used = v.u1; r2used = v.u2;
    idex_mr = v.mr; wreg = v.wr; ex_rd = v.er; ex_wr = v.ew;
    done = v.dn; flush = v.fl;
  endtask

  task automatic clear_inputs();
    r1sel = '0; r2sel = '0; r1used = 1'b0; r2used = 1'b0; idex_mr = 1'b0;
    wreg = '0; ex_rd = 1'b0; ex_wr = 1'b0; done = 1'b0; flush = 1'b0;
    ex_rd2 = 1'b0; ex_wr2 = 1'b0; done2 = 1'b0;
  endtask

  task automatic push_exp(input logic q, input logic d, input logic s, input logic n);
    exp_t e;
    e.q = q; e.d = d; e.s = s; e.n = n;
    exp_q.push_back(e);
  endtask

  // Called right after a negedge drive; samples well before the next posedge.
  task automatic step(input string nm);
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_underflow"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_mem_req"},  int'(mem_req),  int'(e.q));
      chk({nm, "_DC_Stall"}, int'(dc_stall), int'(e.d));
      chk({nm, "_stall"},    int'(stall),    int'(e.s));
      chk({nm, "_nop"},      int'(nop),      int'(e.n));
      chk({nm, "_cnt"},      int'(stall_cycles), exp_cnt);
      chk({nm, "_err"},      int'(mem_err),  0);
      if ((e.d || e.s) && exp_cnt < 65535) exp_cnt++;
    end
  endtask

  initial begin
    int exp2;
    bit xd;

    tbl[0]  = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,0, 1,0,1,0, 1,0,0,0);
    tbl[2]  = mk(0,3,0,1,1,3, 0,0,0,0, 0,0,1,1);
    tbl[3]  = mk(0,3,0,0,1,3, 0,0,0,0, 0,0,0,0);
    tbl[4]  = mk(5,0,1,0,1,5, 0,0,0,0, 0,0,1,1);
    tbl[5]  = mk(5,0,1,0,0,5, 0,0,0,0, 0,0,0,0);
    tbl[6]  = mk(0,7,1,0,1,0, 0,0,0,0, 0,0,1,1);
    tbl[7]  = mk(0,0,0,0,0,0, 0,0,0,1, 0,0,0,1);
    tbl[8]  = mk(0,3,0,1,1,3, 0,0,0,1, 0,0,0,1);
    tbl[9]  = mk(0,3,0,1,1,3, 0,1,1,0, 1,0,1,1);
    tbl[10] = mk(3,4,1,1,1,2, 0,0,0,0, 0,0,0,0);
    tbl[11] = mk(0,0,0,0,0,0, 1,1,1,0, 1,0,0,0);
    tbl[12] = mk(0,0,0,0,0,0, 0,0,1,0, 0,0,0,0);
    tbl[13] = mk(6,6,0,0,1,6, 0,0,0,0, 0,0,0,0);
    tbl[14] = mk(1,6,1,1,1,6, 0,0,0,0, 0,0,1,1);

    // Reset held two cycles with a miss pending.
    clear_inputs();
    rst_n = 1'b0;
    ex_rd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt", int'(stall_cycles), 0);
    chk("rst_err", int'(mem_err), 0);
    chk("rst_cnt2", int'(stall_cycles2), 0);
    chk("rst_err2", int'(mem_err2), 0);
    rst_n = 1'b1;
    exp_cnt = 0;
    push_exp(1, 1, 0, 0);
    step("post_rst");
    @(negedge clk);
    push_exp(0, 1, 0, 0);
    step("busy1");

    // Reset in BUSY aborts; no request once the access is gone.
    @(negedge clk);
    rst_n = 1'b0;
    ex_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    push_exp(0, 0, 0, 0);
    step("abort");

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      push_exp(tbl[i].q, tbl[i].d, tbl[i].s, tbl[i].n);
      step($sformatf("vec%0d", i));
    end

    // Store miss completing on its 5th cycle.
    @(negedge clk);
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      ex_wr = 1'b1;
      done = (k == 4);
      push_exp(k == 0, k != 4, 0, 0);
      step($sformatf("miss%0d", k));
    end
    @(negedge clk);
    clear_inputs();
    push_exp(0, 0, 0, 0);
    step("miss_after");

    // Hazard + flush while a miss is outstanding, then after it completes.
    @(negedge clk);
    idex_mr = 1'b1; wreg = 3'd3; r2sel = 3'd3; r2used = 1'b1; flush = 1'b1;
    ex_rd = 1'b1; done = 1'b0;
    push_exp(1, 1, 0, 0);
    step("prio_idle_miss");
    @(negedge clk);
    push_exp(0, 1, 0, 0);
    step("prio_busy");
    @(negedge clk);
    done = 1'b1;
    push_exp(0, 0, 0, 1);
    step("prio_done");
    @(negedge clk);
    clear_inputs();
    push_exp(0, 0, 0, 0);
    step("prio_after");

    // Small instance: repeated timeouts and counter saturation.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp2 = 0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      ex_rd2 = 1'b1;
      done2 = 1'b0;
      #2;
      xd = ((k % 5) != 4);
      chk($sformatf("to%0d_mem_req", k), int'(mem_req2), int'((k % 5) == 0));
      chk($sformatf("to%0d_DC_Stall", k), int'(dc_stall2), int'(xd));
      chk($sformatf("to%0d_err", k), int'(mem_err2), int'(k >= 5));
      chk($sformatf("to%0d_cnt", k), int'(stall_cycles2), exp2);
      if (xd && exp2 < 7) exp2++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ex_rd2 = 1'b0;
      done2 = 1'b1;
      #2;
      chk($sformatf("sticky%0d_err", k), int'(mem_err2), 1);
      chk($sformatf("sticky%0d_DC_Stall", k), int'(dc_stall2), 0);
      chk($sformatf("sticky%0d_cnt", k), int'(stall_cycles2), 7);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("err_cleared", int'(mem_err2), 0);
    chk("cnt2_cleared", int'(stall_cycles2), 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Produces the hold/bubble controls consumed by the ID/EX pipeline register: `nop`, `stall` and `DC_Stall`.
- Combines three functions:
  - load-use hazard detection between IF/ID and ID/EX;
  - branch flush bubbling;
  - a data-memory access FSM that freezes the pipeline until the data cache reports completion.
- Adds a saturating stall-cycle performance counter and a sticky memory-timeout error.

Parameters:
- MAX_WAIT, 32, maximum cycles a memory access may stay in BUSY before timeout (legal range 2..255).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- IFID_read1RegSel  input  3  rs of the instruction in ID
- IFID_read2RegSel  input  3  rt of the instruction in ID
- IFID_read1Used  input  1  ID instruction reads rs
- IFID_read2Used  input  1  ID instruction reads rt
- IDEX_MemRead  input  1  instruction in EX is a load
- IDEX_Write_register  input  3  destination register of the instruction in EX
- EXMEM_MemRead  input  1  instruction in MEM is a load
- EXMEM_MemWrite  input  1  instruction in MEM is a store
- mem_done  input  1  data cache completes the current access this cycle
- flush  input  1  taken branch/jump resolved; squash the ID instruction
- mem_req  output  1  single-cycle access launch to the data cache
- DC_Stall  output  1  freeze all pipeline registers
- stall  output  1  hold PC and IF/ID; bubble into ID/EX
- nop  output  1  squash control writes into ID/EX
- mem_err  output  1  sticky timeout flag
- stall_cycles  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, wait counter=0, mem_err=0, stall_cycles=0.
  - Combinational outputs evaluate with state=IDLE.
  - Reset mid-BUSY aborts the access; no further mem_req is issued until a new access appears.
- mem_access = EXMEM_MemRead | EXMEM_MemWrite. Both high together is treated as one access.
- FSM states: IDLE, BUSY.
  - IDLE:
    - mem_req = mem_access.
    - If mem_access & ~mem_done: next state BUSY, wait counter cleared to 1.
    - If mem_access & mem_done: hit completes same cycle; stay IDLE.
  - BUSY:
    - mem_req = 0; the access is issued exactly once.
    - On mem_done: next state IDLE.
    - Else if wait counter == MAX_WAIT: next state IDLE, mem_err set (sticky until reset).
    - Else: wait counter increments.
- DC_Stall (combinational) = (IDLE & mem_access & ~mem_done) | (BUSY & ~mem_done & ~timeout), where timeout = BUSY & counter==MAX_WAIT.
  - DC_Stall falls in the same cycle mem_done rises, so the pipeline advances on that edge.
- Load-use hazard:
  - hz = IDEX_MemRead & ((IFID_read1Used & IDEX_Write_register==IFID_read1RegSel) | (IFID_read2Used & IDEX_Write_register==IFID_read2RegSel)).
  - Register 0 is not special.
- Output priority, highest first:
  - DC_Stall=1 → stall=0, nop=0 (the ID/EX register holds anyway; flush is ignored and must be re-presented by its source).
  - Else flush=1 → nop=1, stall=0.
  - Else hz=1 → stall=1, nop=1 (one bubble; the next cycle hz clears because the load has moved to MEM).
  - Else stall=0, nop=0.
- stall_cycles:
  - Increments by 1 on every edge where DC_Stall|stall.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Counts the mem_done cycle only if DC_Stall was still high in that cycle.
- All outputs are glitch-free functions of registered state plus current inputs; there are no combinational loops through DC_Stall.

Test Plan:
- Reset: hold rst_n=0 two cycles with mem_access=1 and mem_done=0 → after release state=IDLE, mem_err=0, stall_cycles=0, and mem_req=1 in the first post-reset cycle.
- Cache hit: EXMEM_MemRead=1 with mem_done=1 in the same cycle → mem_req=1, DC_Stall=0, state stays IDLE, stall_cycles unchanged.
- Miss of 5 cycles: EXMEM_MemWrite=1, mem_done rises on the 5th cycle → mem_req high exactly 1 cycle, DC_Stall high 4 cycles, stall_cycles=4, state returns to IDLE.
- Load-use: IDEX_MemRead=1, IDEX_Write_register=3, IFID_read2RegSel=3, IFID_read2Used=1 → stall=1, nop=1 for one cycle. With IFID_read2Used=0 → stall=0.
- Priority: load-use hazard and flush asserted together → nop=1, stall=0. Add an outstanding miss (DC_Stall=1) → nop=0, stall=0.
- Timeout/saturation: MAX_WAIT=4, CNT_W=3, mem_done never asserted → DC_Stall drops after 4 BUSY cycles, mem_err=1 and sticky. Repeated misses → stall_cycles saturates at 7.
